// File: rtl/instr_fetch.sv
// instr_fetch: drives the program ROM address, assembles 1/2-byte instructions and hands them to the decoder.
module instr_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_imm,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic valid_n, lat_op, lat_imm, two_byte;
  assign rom_address = pc;
  assign two_byte = rom_data[DATA_WIDTH-1 -: 2] == 2'b11;
  // Redirect overrides everything except reset; the byte on rom_data that cycle is dropped.
  always_comb begin
    state_n = state;
    pc_n = pc;
    valid_n = instr_valid;
    lat_op = 1'b0;
    lat_imm = 1'b0;
    if (redirect_valid) begin
      state_n = FETCH_OP;
      pc_n = redirect_target;
      valid_n = 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          lat_op = 1'b1;
          pc_n = pc + ADDR_WIDTH'(1);
          state_n = two_byte ? FETCH_IMM : HOLD;
          valid_n = !two_byte;
        end
        FETCH_IMM: begin
          lat_imm = 1'b1;
          pc_n = pc + ADDR_WIDTH'(1);
          state_n = HOLD;
          valid_n = 1'b1;
        end
        HOLD: begin
          state_n = instr_ready ? FETCH_OP : HOLD;
          valid_n = !instr_ready;
        end
        default: state_n = FETCH_OP;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_OP;
      pc <= RESET_PC;
      instr_valid <= 1'b0;
      instr_opcode <= '0;
      instr_imm <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr_valid <= valid_n;
      if (lat_op) begin
        instr_opcode <= rom_data;
        instr_pc <= pc;
        if (!two_byte) instr_imm <= '0;
      end
      if (lat_imm) instr_imm <= rom_data;
    end
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the program ROM interface. It drives the 8-bit ROM address, samples the combinational ROM data and assembles one- or two-byte instructions.
- Each assembled instruction is presented to the decoder with a valid/ready handshake.
- It holds the program counter and accepts redirects (jumps/branches) from the execute stage.
- It sits between the program ROM and the instruction decoder in the 8-bit CPU.

Parameters:
- ADDR_WIDTH, 8, width of program counter and ROM address.
- DATA_WIDTH, 8, width of ROM data, opcode and immediate.
- RESET_PC, 0, program counter value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_address  output  ADDR_WIDTH  address to program ROM.
- rom_data  input  DATA_WIDTH  ROM byte at rom_address, valid same cycle (combinational ROM).
- instr_valid  output  1  instruction outputs hold a complete instruction.
- instr_ready  input  1  decoder accepts the instruction this cycle.
- instr_opcode  output  DATA_WIDTH  opcode byte.
- instr_imm  output  DATA_WIDTH  immediate byte; 0 for one-byte instructions.
- instr_pc  output  ADDR_WIDTH  address of the opcode byte.
- redirect_valid  input  1  load a new PC this cycle.
- redirect_target  input  ADDR_WIDTH  new PC value.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset). Nothing happens asynchronously.
- Reset values:
  - pc = RESET_PC, so rom_address = RESET_PC.
  - state = FETCH_OP.
  - instr_valid = 0; instr_opcode = 0; instr_imm = 0; instr_pc = 0.
- rom_address = pc, driven combinationally from the pc register.
- Instruction length: opcode[7:6] == 2'b11 gives a two-byte instruction (opcode + immediate). Any other value gives a one-byte instruction.
- pc increment is modulo 2^ADDR_WIDTH: 0xFF + 1 = 0x00, no error.
- State FETCH_OP:
  - Latch instr_opcode <= rom_data and instr_pc <= pc; pc <= pc+1.
  - Two-byte opcode -> FETCH_IMM.
  - Otherwise instr_imm <= 0, instr_valid <= 1 -> HOLD.
- State FETCH_IMM:
  - instr_imm <= rom_data; pc <= pc+1; instr_valid <= 1 -> HOLD.
- State HOLD:
  - instr_valid = 1; all instr_* outputs stable; pc not modified.
  - instr_ready = 1 -> instr_valid <= 0 -> FETCH_OP.
  - instr_ready = 0 -> remain in HOLD, no limit on stall length.
- Latency:
  - One-byte instruction: valid 1 cycle after entering FETCH_OP.
  - Two-byte instruction: valid 2 cycles after entering FETCH_OP.
  - Throughput with ready tied high: one instruction per 2 cycles (one-byte) or per 3 cycles (two-byte).
- instr_ready is ignored when instr_valid = 0.
- redirect_valid = 1 has priority in any state:
  - Next edge: pc <= redirect_target, state <= FETCH_OP, instr_valid <= 0.
  - Any byte sampled that cycle is discarded.
  - In FETCH_IMM, the partially fetched instruction is dropped and never presented.
- Redirect in HOLD with instr_ready = 1 in the same cycle: the held instruction counts as accepted; pc still loads redirect_target.
- Redirect in HOLD with instr_ready = 0: the held instruction is flushed, never accepted.
- reset has priority over redirect and over the handshake. Reset mid-instruction discards everything and restarts at RESET_PC.
- instr_opcode, instr_imm and instr_pc are don't-care when instr_valid = 0, but only change on the latch events above.

Test Plan:
- ROM[0]=0x05, ROM[1]=0x00, ready=1, release reset:
  - cycle 1: instr_valid=1, opcode 0x05, imm 0x00, pc 0x00.
  - cycle 2: valid=0, rom_address=0x01.
  - cycle 3: opcode 0x00, pc 0x01.
- ROM[0]=0xC3, ROM[1]=0x7A, ROM[2]=0x10:
  - first valid at cycle 2: opcode 0xC3, imm 0x7A, pc 0x00.
  - next instruction: opcode 0x10, pc 0x02.
- Backpressure: hold ready=0 for 5 cycles after first valid -> valid stays 1, outputs unchanged, rom_address stays 0x01. Ready=1 -> valid drops the next cycle.
- ROM[0]=0xC3, redirect_valid=1 with target 0x40 during FETCH_IMM:
  - no valid for the 0xC3 instruction.
  - next valid has instr_pc=0x40 and opcode=ROM[0x40].
- Wrap: redirect to 0xFF, ROM[0xFF]=0xC0, ROM[0x00]=0x11 -> opcode 0xC0, imm 0x11, pc 0xFF; the following fetch is at rom_address 0x01.
- Reset asserted while in HOLD with ready=0 -> next cycle valid=0, rom_address=0x00, state FETCH_OP; re-fetch of ROM[0] succeeds.
